// File: rtl/case_3_prod_accum.sv
// Frame accumulator: sums COUNT signed products per frame, then holds the sum for the consumer.
// Define CASE_3_ACC_SAT_EN to make each overflowing addition saturate; otherwise additions wrap.
module case_3_prod_accum #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 dout_ovf,
  output logic                 busy
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  localparam int MSB = ACC_WIDTH - 1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [ACC_WIDTH-1:0] dout_r, dout_nxt;
  logic [ACC_WIDTH-1:0] ext, sum_raw, sum;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 ovf, ovf_nxt;
  logic                 dovf_r, dovf_nxt;
  logic                 add_ovf;
  logic                 accept;

  assign ext     = ACC_WIDTH'($signed(din));
  assign sum_raw = acc + ext;
  assign add_ovf = (acc[MSB] == ext[MSB]) && (sum_raw[MSB] != acc[MSB]);

`ifdef CASE_3_ACC_SAT_EN
  // On overflow both operands share the sign, so clamp toward it.
  assign sum = add_ovf ? {acc[MSB], {(ACC_WIDTH-1){~acc[MSB]}}} : sum_raw;
`else
  assign sum = sum_raw;
`endif

  assign din_rdy  = (state == ACC);
  assign dout_vld = (state == HOLD);
  assign accept   = din_vld && din_rdy;
  assign dout     = dout_r;
  assign dout_ovf = dovf_r;
  assign busy     = (state == HOLD) || (cnt != '0);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    dout_nxt  = dout_r;
    dovf_nxt  = dovf_r;
    unique case (state)
      ACC: begin
        if (accept) begin
          acc_nxt = sum;
          ovf_nxt = ovf | add_ovf;
          if (cnt == LAST) begin
            dout_nxt  = sum;
            dovf_nxt  = ovf | add_ovf;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (dout_rdy) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          dovf_nxt  = 1'b0;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= ACC;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      dout_r <= '0;
      dovf_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      ovf    <= ovf_nxt;
      dout_r <= dout_nxt;
      dovf_r <= dovf_nxt;
    end
  end

endmodule

// File: tb/tb_case_3_prod_accum.sv
// Self-checking bench: three configurations (defaults, 11-bit/4-sample, 1-sample)
// driven with directed and random frames against an arithmetic frame model.
module tb_case_3_prod_accum;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic        din_vld [3];
  logic [15:0] din_s   [3];
  logic        dout_rdy[3];

  logic              din_rdy_x [3];
  logic              dout_vld_x[3];
  logic              dovf_x    [3];
  logic              busy_x    [3];
  logic signed [31:0] dout_x   [3];

  logic [15:0] dout0, dout2;
  logic [10:0] dout1;

  int n_chk  = 0;
  int n_fail = 0;

  case_3_prod_accum u0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .din(din_s[0][9:0]), .din_vld(din_vld[0]), .din_rdy(din_rdy_x[0]),
    .dout(dout0), .dout_vld(dout_vld_x[0]), .dout_rdy(dout_rdy[0]),
    .dout_ovf(dovf_x[0]), .busy(busy_x[0]));

  case_3_prod_accum #(.ACC_WIDTH(11), .COUNT(4)) u1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .din(din_s[1][9:0]), .din_vld(din_vld[1]), .din_rdy(din_rdy_x[1]),
    .dout(dout1), .dout_vld(dout_vld_x[1]), .dout_rdy(dout_rdy[1]),
    .dout_ovf(dovf_x[1]), .busy(busy_x[1]));

  case_3_prod_accum #(.COUNT(1)) u2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .din(din_s[2][9:0]), .din_vld(din_vld[2]), .din_rdy(din_rdy_x[2]),
    .dout(dout2), .dout_vld(dout_vld_x[2]), .dout_rdy(dout_rdy[2]),
    .dout_ovf(dovf_x[2]), .busy(busy_x[2]));

  assign dout_x[0] = 32'($signed(dout0));
  assign dout_x[1] = 32'($signed(dout1));
  assign dout_x[2] = 32'($signed(dout2));

  function automatic int accw(input int sel);
    return (sel == 1) ? 11 : 16;
  endfunction

  function automatic int frame_len(input int sel);
    return (sel == 0) ? 8 : ((sel == 1) ? 4 : 1);
  endfunction

  // Reference: integer arithmetic, range check per addition.
  task automatic ref_frame(input int w, input int s[$],
                           output int sum, output bit ovf);
    int mx, mn, t;
    mx  = (1 << (w - 1)) - 1;
    mn  = -(1 << (w - 1));
    sum = 0;
    ovf = 1'b0;
    foreach (s[i]) begin
      t = sum + s[i];
      if (t > mx || t < mn) begin
        ovf = 1'b1;
`ifdef CASE_3_ACC_SAT_EN
        t = (t > mx) ? mx : mn;
`else
        t = (t > mx) ? t - (1 << w) : t + (1 << w);
`endif
      end
      sum = t;
    end
  endtask

  // Drives one frame, then presents/holds/drains the output; reports observations.
  task automatic drive_frame(input int sel, input int s[$], input int pct,
                             input int gap, input int hold,
                             output int got, output bit gov,
                             output bit tim, output bit stab);
    int k, cyc;
    bit v;
    k    = 0;
    cyc  = 0;
    tim  = 1'b1;
    stab = 1'b1;
    dout_rdy[sel] = (hold == 0);
    while (k < s.size() && cyc < 2000) begin
      @(negedge ap_clk);
      cyc++;
      if (dout_vld_x[sel]) tim = 1'b0;
      if (gap > 0) v = ((cyc - 1) % (gap + 1)) == 0;
      else v = ($urandom_range(99) < pct);
      din_vld[sel] = v;
      din_s[sel]   = 16'(s[k]);
      if (v && din_rdy_x[sel]) k++;
    end
    @(negedge ap_clk);
    din_vld[sel] = 1'b0;
    if (k < s.size() || !dout_vld_x[sel]) tim = 1'b0;
    got = dout_x[sel];
    gov = dovf_x[sel];
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      if (din_rdy_x[sel] || !dout_vld_x[sel] ||
          dout_x[sel] !== got || dovf_x[sel] !== gov) stab = 1'b0;
    end
    dout_rdy[sel] = 1'b1;
    @(negedge ap_clk);
    if (dout_vld_x[sel] || !din_rdy_x[sel]) tim = 1'b0;
    dout_rdy[sel] = (hold == 0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      din_vld[i]  = 1'b1;
      din_s[i]    = 16'd5;
      dout_rdy[i] = 1'b1;
    end
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    for (int i = 0; i < 3; i++) din_vld[i] = 1'b0;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (din_rdy_x[i] !== 1'b1 || dout_vld_x[i] !== 1'b0 ||
          busy_x[i] !== 1'b0 || dout_x[i] !== 0 || dovf_x[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b busy=%b dout=%0d ovf=%b want 1 0 0 0 0",
                 i, din_rdy_x[i], dout_vld_x[i], busy_x[i], dout_x[i], dovf_x[i]);
      end
    end
  endtask

  task automatic test_basic;
    int q[$];
    int got;
    bit gov, tim, stab;
    q = {100, 200, -50, 25, 0, 0, 0, 0};
    drive_frame(0, q, 100, 0, 0, got, gov, tim, stab);
    n_chk++;
    if (got !== 275 || gov !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: dout=%0d ovf=%b want 275 0", got, gov);
    end
    n_chk++;
    if (!tim) begin
      n_fail++;
      $display("FAIL basic_timing: dout_vld pulse wrong, got bad want single cycle");
    end
  endtask

  task automatic test_backpressure;
    int q[$];
    int got, es;
    bit gov, eo, tim, stab;
    q = {300, -7, 12, 44, -100, 9, 1, 2};
    ref_frame(16, q, es, eo);
    drive_frame(0, q, 70, 0, 5, got, gov, tim, stab);
    n_chk++;
    if (got !== es || gov !== eo) begin
      n_fail++;
      $display("FAIL bp_sum: dout=%0d ovf=%b want %0d %b", got, gov, es, eo);
    end
    n_chk++;
    if (!stab || !tim) begin
      n_fail++;
      $display("FAIL bp_hold: stable=%b timing=%b want 1 1", stab, tim);
    end
  endtask

  task automatic test_overflow;
    int q[$];
    int got, es;
    bit gov, eo, tim, stab;
    for (int p = 0; p < 2; p++) begin
      q = (p == 0) ? {511, 511, 511, 511} : {-512, -512, -512, -512};
`ifdef CASE_3_ACC_SAT_EN
      es = (p == 0) ? 1023 : -1024;
`else
      es = (p == 0) ? -4 : 0;
`endif
      drive_frame(1, q, 100, 0, 0, got, gov, tim, stab);
      n_chk++;
      if (got !== es || gov !== 1'b1 || !tim) begin
        n_fail++;
        $display("FAIL ovf[%0d]: dout=%0d ovf=%b tim=%b want %0d 1 1",
                 p, got, gov, tim, es);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int q[$];
    int got;
    bit gov, tim, stab;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      din_vld[1] = 1'b1;
      din_s[1]   = 16'd7;
    end
    @(negedge ap_clk);
    din_vld[1] = 1'b0;
    n_chk++;
    if (busy_x[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: busy=%b want 1", busy_x[1]);
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    n_chk++;
    if (busy_x[1] !== 1'b0 || din_rdy_x[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_rst: busy=%b rdy=%b want 0 1", busy_x[1], din_rdy_x[1]);
    end
    q = {1, 1, 1, 1};
    drive_frame(1, q, 0, 2, 0, got, gov, tim, stab);
    n_chk++;
    if (got !== 4 || gov !== 1'b0 || !tim) begin
      n_fail++;
      $display("FAIL midframe_sum: dout=%0d ovf=%b tim=%b want 4 0 1", got, gov, tim);
    end
  endtask

  task automatic test_random;
    int q[$];
    int got, es, sel, r;
    bit gov, eo, tim, stab;
    for (int f = 0; f < 16; f++) begin
      sel = f % 3;
      q = {};
      for (int i = 0; i < frame_len(sel); i++) begin
        r = int'($urandom_range(3));
        if (r == 0) q.push_back(511);
        else if (r == 1) q.push_back(-512);
        else q.push_back(int'($urandom_range(1023)) - 512);
      end
      ref_frame(accw(sel), q, es, eo);
      drive_frame(sel, q, 50, 0, int'($urandom_range(3)), got, gov, tim, stab);
      n_chk++;
      if (got !== es || gov !== eo || !tim || !stab) begin
        n_fail++;
        $display("FAIL rand[%0d] sel%0d: dout=%0d ovf=%b tim=%b stab=%b want %0d %b 1 1",
                 f, sel, got, gov, tim, stab, es, eo);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din_vld[i]  = 1'b0;
      din_s[i]    = 16'd0;
      dout_rdy[i] = 1'b0;
    end
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_reset_midframe;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/case_3_prod_accum.md
CASE_3_PROD_ACCUM -- requirements
Module: case_3_prod_accum

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 10: width of the signed product input.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: width of the signed accumulator and output (ACC_WIDTH >= DIN_WIDTH).
REQ-003 SHALL have parameter COUNT, default 8: number of products per frame (COUNT >= 1).
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port din, input, DIN_WIDTH bits: signed product from the upstream multiplier.
REQ-007 SHALL have ports din_vld (input, 1 bit) and din_rdy (output, 1 bit): the input handshake.
REQ-008 SHALL have port dout, output, ACC_WIDTH bits: the signed frame sum.
REQ-009 SHALL have ports dout_vld (output, 1 bit) and dout_rdy (input, 1 bit): the output handshake.
REQ-010 SHALL have port dout_ovf, output, 1 bit: overflow occurred during the frame now presented on dout.
REQ-011 SHALL have port busy, output, 1 bit: high when at least one sample of the current frame has been accepted, or while in HOLD.

Function
REQ-012 SHALL implement a two-state FSM with states ACC and HOLD.
REQ-013 In ACC, SHALL drive din_rdy=1 and dout_vld=0.
REQ-014 In HOLD, SHALL drive din_rdy=0 and dout_vld=1.
REQ-015 A sample SHALL be accepted only on a cycle with din_vld=1 and din_rdy=1; in all other cycles the accumulator and the counter SHALL hold.
REQ-016 On acceptance, SHALL sign-extend din to ACC_WIDTH, add it to the accumulator, and increment the sample counter (range 0..COUNT-1).
REQ-017 On the acceptance where the counter equals COUNT-1, SHALL register the final sum into dout, set the state to HOLD, and assert dout_vld on the next cycle (latency 1 cycle from the last accept).
REQ-018 The final sum SHALL include the last accepted sample.
REQ-019 While dout_vld=1 and dout_rdy=0, dout and dout_ovf SHALL remain stable.
REQ-020 On a cycle in HOLD with dout_rdy=1, SHALL return to ACC on the next cycle, with the accumulator, counter and overflow flag cleared.
REQ-021 No sample SHALL be accepted in the cycle the output handshake completes.
REQ-022 With COUNT=1, every accepted sample SHALL produce one output frame.
REQ-023 Overflow SHALL be evaluated on every individual addition.
REQ-024 dout_ovf SHALL be sticky for the frame and SHALL be cleared when the next frame starts.
REQ-025 dout_vld SHALL NOT depend combinationally on dout_rdy.
REQ-026 din_rdy SHALL NOT depend combinationally on din_vld.

Reset
REQ-027 On an ap_clk edge with ap_rst=1, SHALL set state to ACC and clear accumulator, counter, dout, dout_ovf, dout_vld and busy to 0, with din_rdy=1 on the following cycle.
REQ-028 Reset SHALL take priority over any handshake in the same cycle.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame.

Configuration
REQ-030 SHALL support macro CASE_3_ACC_SAT_EN.
REQ-031 When CASE_3_ACC_SAT_EN is defined, each addition that overflows SHALL clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) and set the overflow flag.
REQ-032 When CASE_3_ACC_SAT_EN is undefined, additions SHALL wrap (two's complement) and still set the overflow flag.

Verification
REQ-033 Defaults, samples 100, 200, -50, 25, 0, 0, 0, 0 with continuous din_vld and dout_rdy=1 -> dout=275, dout_ovf=0, dout_vld high exactly one cycle, starting 1 cycle after the 8th accept.
REQ-034 ACC_WIDTH=11, COUNT=4, samples 511 x4 -> with macro: dout=1023, dout_ovf=1; without macro: dout=-4, dout_ovf=1.
REQ-035 ACC_WIDTH=11, COUNT=4, samples -512 x4 -> with macro: dout=-1024, dout_ovf=1; without macro: dout=0, dout_ovf=1.
REQ-036 Frame complete with dout_rdy held low 5 cycles -> dout and dout_ovf constant, din_rdy=0 throughout; din_rdy=1 the cycle after dout_rdy rises.
REQ-037 COUNT=4: accept 3 samples of 7, assert ap_rst 1 cycle, then samples 1, 1, 1, 1 with din_vld gaps of 2 cycles -> dout=4, dout_ovf=0.
